i2c_master_seq: RTL

Single-byte I2C master sequencer driving the upstream side of `i2c_addr_translator`. Accepts one command (7-bit address, R/W, write byte), generates START, address, data, ACK/NACK and STOP on SCL/SDA, and returns read data and ACK status. It is the only upstream master on the translator, so translator scenarios can run from a command interface instead of hand-toggled SCL.

---
 rtl/i2c_pkg.sv | 10 +
 rtl/i2c_qtr_tick.sv | 25 ++
 rtl/i2c_master_seq.sv | 100 ++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding and bus constants for the I2C master sequencer
package i2c_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WR, S_WR_ACK, S_RD, S_RD_ACK, S_STOP, S_DONE
  } state_t;
  localparam logic [1:0] Q_SETUP = 2'd0;
  localparam logic [1:0] Q_RISE = 2'd2;
  localparam logic I2C_ACK = 1'b0;
  localparam logic I2C_NACK = 1'b1;
endpackage

// File: rtl/i2c_qtr_tick.sv
// i2c_qtr_tick: QTR-cycle quarter counter with stretch hold and 2-bit quarter index
module i2c_qtr_tick #(
  parameter int QTR = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       hold,
  output logic       tick,
  output logic [1:0] qtr
);
  logic [9:0] cnt;
  assign tick = run && !hold && cnt == 10'(QTR - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      qtr <= '0;
    end else if (!run) begin
      cnt <= '0;
      qtr <= '0;
    end else if (!hold) begin
      cnt <= tick ? '0 : cnt + 10'd1;
      qtr <= qtr + {1'b0, tick};
    end
endmodule

// File: rtl/i2c_master_seq.sv
// i2c_master_seq: single-byte I2C master, one command in, START/addr/data/STOP out, one response back
import i2c_pkg::*;

module i2c_master_seq #(
  parameter int QTR = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_addr,
  input  logic       cmd_rw,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_nack,
  output logic       scl_out,
  output logic       sda_out,
  input  logic       scl_in,
  input  logic       sda_in
);
  state_t st, nst;
  logic [2:0] bit_cnt, nbit;
  logic [7:0] sh, nsh, wd;
  logic [1:0] qtr, nq;
  logic rw, tick, run, hold, end_q, samp, accept, bit_st, nscl, nsda;
  assign run = st != S_IDLE && st != S_DONE;
  assign hold = scl_out && qtr[1] && !scl_in;
  assign end_q = tick && qtr == 2'd3;
  assign samp = tick && qtr == Q_RISE;
  assign accept = cmd_valid && cmd_ready;
  assign nq = qtr + {1'b0, tick};
  i2c_qtr_tick #(.QTR(QTR)) u_tick (.clk(clk), .rst(rst), .run(run), .hold(hold), .tick(tick), .qtr(qtr));
  always_comb begin
    nst = st;
    nbit = bit_cnt;
    nsh = sh;
    case (st)
      S_IDLE: begin
        nst = accept ? S_START : st;
        nsh = accept ? {cmd_addr, cmd_rw} : sh;
      end
      S_START: nst = end_q ? S_ADDR : st;
      S_ADDR, S_WR, S_RD:
        if (end_q) begin
          nbit = bit_cnt + 3'd1;
          nsh = {sh[6:0], 1'b0};
          if (bit_cnt == 3'd7)
            nst = st == S_ADDR ? S_ADDR_ACK : st == S_WR ? S_WR_ACK : S_RD_ACK;
        end
      S_ADDR_ACK:
        if (end_q) begin
          nst = rsp_nack ? S_STOP : rw ? S_RD : S_WR;
          nsh = wd;
        end
      S_WR_ACK, S_RD_ACK: nst = end_q ? S_STOP : st;
      S_STOP: nst = end_q ? S_DONE : st;
      default: nst = S_IDLE;
    endcase
  end
  // Line levels are derived from the state/quarter being entered so they change only on quarter edges
  always_comb begin
    bit_st = nst inside {S_ADDR, S_ADDR_ACK, S_WR, S_WR_ACK, S_RD, S_RD_ACK};
    nscl = bit_st ? nq[1] : nst == S_STOP ? nq != Q_SETUP : 1'b1;
    nsda = nst == S_START ? ~nq[1] :
           nst == S_STOP ? nq[1] :
           nst == S_RD_ACK ? I2C_NACK :
           nst inside {S_ADDR, S_WR} ? nsh[7] : 1'b1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= S_IDLE;
      bit_cnt <= '0;
      sh <= '0;
      wd <= '0;
      rw <= 1'b0;
      scl_out <= 1'b1;
      sda_out <= 1'b1;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_nack <= 1'b0;
    end else begin
      st <= nst;
      bit_cnt <= nbit;
      sh <= nsh;
      scl_out <= nscl;
      sda_out <= nsda;
      cmd_ready <= nst == S_IDLE;
      rsp_valid <= nst == S_DONE;
      if (accept) begin
        wd <= cmd_wdata;
        rw <= cmd_rw;
        rsp_rdata <= '0;
        rsp_nack <= 1'b0;
      end
      if (samp && (st == S_ADDR_ACK || st == S_WR_ACK)) rsp_nack <= sda_in;
      if (samp && st == S_RD) rsp_rdata <= {rsp_rdata[6:0], sda_in};
    end
endmodule
